// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
// Top-level sequencer for the UART matrix multiplier.
//   1. Received UART bytes are written row-major into the A operand memory,
//      then into the B operand memory (N*N bytes each).
//   2. The multiplier is started with a one-cycle pulse and the sequencer
//      waits for its done indication.
//   3. The NxN result matrix is read back and streamed to the UART
//      transmitter, two bytes per element, MSB first.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   rx_valid   in   one-cycle strobe, rx_byte holds a new byte
//   rx_byte    in   received byte
//   a_we       out  write enable, A memory
//   b_we       out  write enable, B memory
//   ld_addr    out  A/B write address (row-major index)
//   ld_data    out  A/B write data
//   mm_start   out  one-cycle start pulse to the multiplier
//   mm_done    in   multiplier finished (only looked at while waiting)
//   res_addr   out  result memory read address
//   res_rdata  in   result data, valid one cycle after res_addr
//   tx_start   out  one-cycle request to UART TX, tx_byte valid same cycle
//   tx_byte    out  byte to transmit
//   tx_busy    in   UART TX busy
//   busy       out  high from START until the final byte is handed to TX
//   ovf        out  sticky: a received byte was dropped outside loading
//   dbg_state  out  current FSM state (debug / checker visibility)
//
// Handshake: rx_valid is a one-cycle strobe with no back-pressure; a byte
// arriving outside LOAD_A/LOAD_B is dropped and flagged on ovf. Towards the
// transmitter a byte is handed over by a one-cycle tx_start, issued only
// after tx_busy was sampled low, and followed by a guard cycle in which
// tx_busy is ignored because the transmitter raises it one cycle late.
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int RW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_byte,
    output logic          a_we,
    output logic          b_we,
    output logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          mm_start,
    input  logic          mm_done,
    output logic [AW-1:0] res_addr,
    input  logic [RW-1:0] res_rdata,
    output logic          tx_start,
    output logic [7:0]    tx_byte,
    input  logic          tx_busy,
    output logic          busy,
    output logic          ovf,
    output logic [3:0]    dbg_state
);

    localparam int            NN   = N * N;
    localparam logic [AW-1:0] LAST = AW'(NN - 1);

    typedef enum logic [3:0] {
        LOAD_A = 4'd0,
        LOAD_B = 4'd1,
        START  = 4'd2,
        WAIT   = 4'd3,
        FETCH  = 4'd4,
        TXH    = 4'd5,
        TXH_G  = 4'd6,
        TXL    = 4'd7,
        TXL_G  = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] k_q, k_d;
    logic          fetch_ph_q, fetch_ph_d;
    logic [RW-1:0] res_q, res_d;
    logic          a_we_q, a_we_d;
    logic          b_we_q, b_we_d;
    logic [AW-1:0] ld_addr_q, ld_addr_d;
    logic [DW-1:0] ld_data_q, ld_data_d;
    logic          mm_start_q, mm_start_d;
    logic [AW-1:0] res_addr_q, res_addr_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          busy_q, busy_d;
    logic          ovf_q, ovf_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOAD_A;
            cnt_q      <= '0;
            k_q        <= '0;
            fetch_ph_q <= 1'b0;
            res_q      <= '0;
            a_we_q     <= 1'b0;
            b_we_q     <= 1'b0;
            ld_addr_q  <= '0;
            ld_data_q  <= '0;
            mm_start_q <= 1'b0;
            res_addr_q <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            fetch_ph_q <= fetch_ph_d;
            res_q      <= res_d;
            a_we_q     <= a_we_d;
            b_we_q     <= b_we_d;
            ld_addr_q  <= ld_addr_d;
            ld_data_q  <= ld_data_d;
            mm_start_q <= mm_start_d;
            res_addr_q <= res_addr_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        fetch_ph_d = fetch_ph_q;
        res_d      = res_q;
        a_we_d     = 1'b0;
        b_we_d     = 1'b0;
        ld_addr_d  = ld_addr_q;
        ld_data_d  = ld_data_q;
        mm_start_d = 1'b0;
        res_addr_d = res_addr_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;

        // Bytes are only consumed while loading; anything else is dropped.
        if (rx_valid && (state_q != LOAD_A) && (state_q != LOAD_B)) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            LOAD_A: begin
                if (rx_valid) begin
                    a_we_d    = 1'b1;
                    ld_addr_d = cnt_q;
                    ld_data_d = rx_byte;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                if (rx_valid) begin
                    b_we_d    = 1'b1;
                    ld_addr_d = cnt_q;
                    ld_data_d = rx_byte;
                    if (cnt_q == LAST) begin
                        // Raised on entry so the registered pulse and busy
                        // line up with the START cycle itself.
                        cnt_d      = '0;
                        mm_start_d = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mm_done) begin
                    res_addr_d = k_q;
                    fetch_ph_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // Phase 0: address is out, memory registers it.
                // Phase 1: read data is valid and captured.
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    fetch_ph_d = 1'b0;
                    res_d      = res_rdata;
                    state_d    = TXH;
                end
            end
            TXH: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = res_q[RW-1:RW-8];
                    state_d    = TXH_G;
                end
            end
            TXH_G: begin
                state_d = TXL;
            end
            TXL: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = res_q[7:0];
                    state_d    = TXL_G;
                end
            end
            TXL_G: begin
                if (k_q == LAST) begin
                    busy_d  = 1'b0;
                    k_d     = '0;
                    state_d = LOAD_A;
                end else begin
                    k_d        = k_q + 1'b1;
                    res_addr_d = k_q + 1'b1;
                    fetch_ph_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    assign a_we      = a_we_q;
    assign b_we      = b_we_q;
    assign ld_addr   = ld_addr_q;
    assign ld_data   = ld_data_q;
    assign mm_start  = mm_start_q;
    assign res_addr  = res_addr_q;
    assign tx_start  = tx_start_q;
    assign tx_byte   = tx_byte_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_seq_ctrl
// Directed bench for matmul_seq_ctrl (N=2). Contains a registered result
// memory holding C = 19,22,43,50 and a UART TX model that raises busy one
// cycle after a tx_start and holds it for a programmable number of cycles.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge or by monitors on the rising edge.
// -----------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

    localparam int AW = 4;

    localparam logic [3:0] S_LOAD_A = 4'd0;
    localparam logic [3:0] S_WAIT   = 4'd3;
    localparam logic [3:0] S_TXL    = 4'd7;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          a_we;
    logic          b_we;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          mm_start;
    logic          mm_done;
    logic [AW-1:0] res_addr;
    logic [15:0]   res_rdata;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          tx_busy;
    logic          busy;
    logic          ovf;
    logic [3:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    matmul_seq_ctrl #(.N(2), .DW(8), .RW(16), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .a_we      (a_we),
        .b_we      (b_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .mm_start  (mm_start),
        .mm_done   (mm_done),
        .res_addr  (res_addr),
        .res_rdata (res_rdata),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // ---------------- result memory model ----------------
    always @(posedge clk) begin
        case (res_addr)
            4'd0:    res_rdata <= 16'd19;
            4'd1:    res_rdata <= 16'd22;
            4'd2:    res_rdata <= 16'd43;
            4'd3:    res_rdata <= 16'd50;
            default: res_rdata <= 16'hDEAD;
        endcase
    end

    // ---------------- UART TX model ----------------
    int tx_hold = 2;
    int tx_cnt  = 0;
    always @(posedge clk) begin
        if (tx_start) tx_cnt <= tx_hold;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0);

    // ---------------- monitors ----------------
    logic [7:0] tx_q[$];
    int we_cnt      = 0;
    int mm_cnt      = 0;
    int viol_cnt    = 0;
    logic busy_at_tx = 1'b0;
    logic prev_tx   = 1'b0;
    always @(posedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_byte);
            busy_at_tx = busy;
            if (tx_busy) viol_cnt++;
            if (prev_tx) viol_cnt++;
        end
        prev_tx = tx_start;
        if (a_we || b_we) we_cnt++;
        if (a_we && b_we) viol_cnt++;
        if ((a_we || b_we) && ld_addr >= 4'd4) viol_cnt++;
        if (mm_start) begin
            mm_cnt++;
            if (dbg_state != 4'd2) viol_cnt++;
        end
    end

    // ---------------- scoreboard expectation ----------------
    logic [7:0] exp_q[$];
    initial begin
        exp_q = '{8'h00, 8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32};
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input logic is_a,
                             input logic [3:0] addr, input logic expect_we);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        n_checks++;
        if (expect_we) begin
            if ({a_we, b_we, ld_addr, ld_data} !== {is_a, ~is_a, addr, b}) begin
                n_fail++;
                $display("FAIL load_write byte=%02h got we_a=%0b we_b=%0b addr=%0d data=%02h want we_a=%0b we_b=%0b addr=%0d data=%02h",
                         b, a_we, b_we, ld_addr, ld_data, is_a, ~is_a, addr, b);
            end
        end else begin
            if ({a_we, b_we} !== 2'b00) begin
                n_fail++;
                $display("FAIL dropped_byte_we got we_a=%0b we_b=%0b want 0 0", a_we, b_we);
            end
        end
    endtask

    task automatic load_all(input string name);
        int mm_base;
        mm_base = mm_cnt;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i + 1), (i < 4), 4'(i % 4), 1'b1);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (mm_cnt - mm_base !== 1) begin
            n_fail++;
            $display("FAIL %s mm_start_pulses got %0d want 1", name, mm_cnt - mm_base);
        end
    endtask

    task automatic run_result(input int hold, input string name);
        int base;
        int viol_base;
        int cyc;
        tx_hold   = hold;
        base      = tx_q.size();
        viol_base = viol_cnt;
        cyc = 0;
        while (dbg_state !== S_WAIT && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (dbg_state !== S_WAIT) begin
            n_fail++;
            $display("FAIL %s reach_wait got state=%0d want %0d", name, dbg_state, S_WAIT);
        end
        @(negedge clk);
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
        cyc = 0;
        while (!((tx_q.size() - base) == 8 && busy == 1'b0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (tx_q.size() - base !== 8) begin
            n_fail++;
            $display("FAIL %s tx_count got %0d want 8", name, tx_q.size() - base);
        end
        for (int i = 0; i < 8; i++) begin
            if (base + i < tx_q.size()) begin
                n_checks++;
                if (tx_q[base + i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s tx_byte[%0d] got %02h want %02h", name, i, tx_q[base + i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (busy_at_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_at_last_byte got %0b want 1", name, busy_at_tx);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, dbg_state} !== {1'b0, S_LOAD_A}) begin
            n_fail++;
            $display("FAIL %s end_state got busy=%0b state=%0d want busy=0 state=%0d", name, busy, dbg_state, S_LOAD_A);
        end
        n_checks++;
        if (viol_cnt !== viol_base) begin
            n_fail++;
            $display("FAIL %s protocol_violations got %0d want 0", name, viol_cnt - viol_base);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int we_base;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({a_we, b_we, ld_addr, ld_data, mm_start, res_addr, tx_start, tx_byte, busy, ovf} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %08h want 0",
                     {a_we, b_we, ld_addr, ld_data, mm_start, res_addr, tx_start, tx_byte, busy, ovf});
        end
        rst = 1'b1;
        we_base = we_cnt;
        // mm_done outside WAIT must be ignored
        @(negedge clk);
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (dbg_state !== S_LOAD_A) begin
            n_fail++;
            $display("FAIL reset_state got %0d want %0d", dbg_state, S_LOAD_A);
        end
        n_checks++;
        if (we_cnt !== we_base) begin
            n_fail++;
            $display("FAIL reset_idle_we got %0d want 0", we_cnt - we_base);
        end
    endtask

    task automatic test_full_run();
        load_all("full_run");
        run_result(2, "full_run");
    endtask

    task automatic test_backpressure();
        load_all("backpressure");
        run_result(500, "backpressure");
    endtask

    task automatic test_drop();
        int we_base;
        load_all("drop");
        repeat (3) @(negedge clk);
        we_base = we_cnt;
        send_byte(8'hAA, 1'b1, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ovf, dbg_state} !== {1'b1, S_WAIT}) begin
            n_fail++;
            $display("FAIL drop_ovf got ovf=%0b state=%0d want ovf=1 state=%0d", ovf, dbg_state, S_WAIT);
        end
        n_checks++;
        if (we_cnt !== we_base) begin
            n_fail++;
            $display("FAIL drop_no_we got %0d want 0", we_cnt - we_base);
        end
        run_result(3, "drop_run1");
        load_all("drop_reload");
        run_result(1, "drop_run2");
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_ovf_sticky got %0b want 1", ovf);
        end
    endtask

    task automatic test_midop_reset();
        int base;
        int cyc;
        load_all("midop");
        tx_hold = 2;
        base = tx_q.size();
        repeat (2) @(negedge clk);
        mm_done = 1'b1;
        @(negedge clk);
        mm_done = 1'b0;
        cyc = 0;
        while (!((tx_q.size() - base) >= 3 && dbg_state == S_TXL) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if ({tx_q.size() - base, dbg_state} !== {32'd3, S_TXL}) begin
            n_fail++;
            $display("FAIL midop_reach_txl got bytes=%0d state=%0d want bytes=3 state=%0d",
                     tx_q.size() - base, dbg_state, S_TXL);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({a_we, b_we, ld_addr, ld_data, mm_start, res_addr, tx_start, tx_byte, busy, ovf} !== 30'd0) begin
            n_fail++;
            $display("FAIL midop_reset_outputs got %08h want 0",
                     {a_we, b_we, ld_addr, ld_data, mm_start, res_addr, tx_start, tx_byte, busy, ovf});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (tx_q.size() - base !== 3) begin
            n_fail++;
            $display("FAIL midop_no_extra_tx got %0d want 3", tx_q.size() - base);
        end
        load_all("midop_reload");
        run_result(2, "midop_run");
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        mm_done  = 1'b0;
        test_reset();
        test_full_run();
        test_backpressure();
        test_drop();
        test_midop_reset();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
